// File: rtl/target_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : target_read_ctrl
// Purpose  : Streams training targets from a sample memory, one handshake per
//            sample, over a programmed number of epochs.
// Revision : 1.0 - initial release
// ============================================================================
module target_read_ctrl #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 4,
    parameter int EWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [EWIDTH-1:0] epochs,
    input  logic [AWIDTH-1:0] last_addr,
    output logic              mem_en,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic [DWIDTH-1:0] t_out,
    output logic              t_valid,
    input  logic              t_ready,
    output logic [AWIDTH-1:0] sample_idx,
    output logic [EWIDTH-1:0] epoch_cnt,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_CAPT = 3'd2,
        S_HOLD = 3'd3,
        S_NEXT = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH-1:0] r_last;
    logic [EWIDTH-1:0] r_epochs;
    logic [EWIDTH-1:0] r_epoch_cnt;
    logic [DWIDTH-1:0] r_t_out;
    logic [AWIDTH-1:0] r_sample_idx;
    logic              r_zero_done;

    logic              w_addr_last;
    logic [EWIDTH-1:0] w_cnt_inc;
    logic              w_final;
    logic              w_abort;

    assign w_addr_last = (r_addr == r_last);
    // epoch_cnt is always below r_epochs inside a run, so the increment cannot wrap
    assign w_cnt_inc   = r_epoch_cnt + {{(EWIDTH-1){1'b0}}, 1'b1};
    assign w_final     = w_addr_last && (w_cnt_inc == r_epochs);
    assign w_abort     = abort && (r_state != S_IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start && (epochs != '0)) w_next = S_READ;
            S_READ: w_next = S_CAPT;
            S_CAPT: w_next = S_HOLD;
            S_HOLD: if (t_ready) w_next = S_NEXT;
            S_NEXT: w_next = w_final ? S_IDLE : S_READ;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_last       <= '0;
            r_epochs     <= '0;
            r_epoch_cnt  <= '0;
            r_t_out      <= '0;
            r_sample_idx <= '0;
            r_zero_done  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_zero_done <= (r_state == S_IDLE) && start && (epochs == '0);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= '0;
                        r_epoch_cnt <= '0;
                        r_epochs    <= epochs;
                        r_last      <= last_addr;
                    end
                end
                S_CAPT: begin
                    if (!w_abort) begin
                        r_t_out      <= mem_dout;
                        r_sample_idx <= r_addr;
                    end
                end
                S_NEXT: begin
                    if (!w_abort) begin
                        if (w_addr_last) begin
                            r_addr      <= '0;
                            r_epoch_cnt <= w_cnt_inc;
                        end else begin
                            r_addr <= r_addr + {{(AWIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en     = (r_state == S_READ);
    assign mem_addr   = r_addr;
    assign t_out      = r_t_out;
    assign t_valid    = (r_state == S_HOLD);
    assign sample_idx = r_sample_idx;
    assign epoch_cnt  = r_epoch_cnt;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_zero_done || ((r_state == S_NEXT) && w_final && !w_abort);

endmodule
`default_nettype wire

// File: doc/target_read_ctrl.md
TARGET_READ_CTRL -- requirements
Module: target_read_ctrl

Interface
REQ-001 Parameter DWIDTH, default 16: target data width, fixed point 00_0000.0000_0000_00, unsigned.
REQ-002 Parameter AWIDTH, default 4: target-memory address width, 16 sample slots.
REQ-003 Parameter EWIDTH, default 16: epoch counter width.
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1: reset, asynchronous and active-high.
REQ-006 Port start  input  1: one-cycle pulse that begins a run; sampled only in IDLE.
REQ-007 Port abort  input  1: terminates a run; takes effect at the next edge from any non-IDLE state.
REQ-008 Port epochs  input  EWIDTH: number of full passes; sampled at start.
REQ-009 Port last_addr  input  AWIDTH: highest sample address per pass; sampled at start.
REQ-010 Port mem_en  output  1: read enable to the target memory.
REQ-011 Port mem_addr  output  AWIDTH: read address to the target memory.
REQ-012 Port mem_dout  input  DWIDTH: target memory read data, tri-stated when not read.
REQ-013 Port t_out  output  DWIDTH: captured target value for the backprop datapath.
REQ-014 Port t_valid  output  1: t_out holds a valid target.
REQ-015 Port t_ready  input  1: datapath accepts t_out.
REQ-016 Port sample_idx  output  AWIDTH: address of the sample currently in t_out.
REQ-017 Port epoch_cnt  output  EWIDTH: number of completed passes in the current run.
REQ-018 Port busy  output  1: high in every state except IDLE.
REQ-019 Port done  output  1: one-cycle pulse on normal completion, epochs=0 included, but not on abort.

Function
REQ-020 FSM states: IDLE, READ, CAPT, HOLD, NEXT.
- IDLE -> READ on start with epochs!=0.
- IDLE -> IDLE with done=1 for one cycle on start with epochs=0; no memory access.
REQ-021 READ lasts exactly one cycle: mem_en=1, mem_addr=current address; next state is CAPT.
REQ-022 CAPT lasts one cycle with mem_en=0.
- The memory drives data in this cycle.
- At the CAPT->HOLD edge, t_out<=mem_dout and sample_idx<=address.
- t_out never samples mem_dout in any other state, so Z is never captured.
REQ-023 HOLD: t_valid=1.
- t_out, sample_idx and t_valid are stable until t_valid and t_ready are both high at an edge.
- The handshake moves the FSM to NEXT.
REQ-024 NEXT lasts one cycle, t_valid=0.
- If address<last_addr: address+1, -> READ.
- Otherwise: address wraps to 0 and epoch_cnt+1.
  - If the new epoch_cnt equals epochs, pulse done and go to IDLE.
  - If not, -> READ.
REQ-025 Latency: start edge -> READ in the next cycle -> t_valid asserted 3 cycles after the start edge.
REQ-026 Throughput with t_ready held high: one target every 4 cycles.
REQ-027 mem_en is high only in READ and never for two consecutive cycles.
REQ-028 last_addr=0 gives one sample per pass; last_addr=15 covers all 16 slots; the address never exceeds last_addr.
REQ-029 epoch_cnt does not wrap within a run.
- It stops at epochs, so the epochs maximum of 2^EWIDTH-1 completes correctly.
REQ-030 start while busy is ignored; epochs and last_addr changes while busy have no effect on the run.
REQ-031 Abort at an edge takes priority over every transition, including a handshake in HOLD.
- Next state IDLE, t_valid=0, mem_en=0, no done.
- epoch_cnt holds its value until the next start.
REQ-032 Start and abort together in IDLE: the start is honoured.
REQ-033 At the start that begins a run: address<=0, epoch_cnt<=0, t_valid<=0.

Reset
REQ-034 rst=1 immediately forces these values, regardless of clk:
- state=IDLE, mem_en=0, mem_addr=0.
- t_out=0, t_valid=0, sample_idx=0, epoch_cnt=0.
- busy=0, done=0.
REQ-035 Reset mid-run discards the run; after rst falls, the block waits for a new start.

Verification
REQ-036 Memory model: slot 0 = 16'h0400 (value 1.0), slots 1-15 = 0, 1-cycle registered read, Z when not read.
- Stimulus: epochs=1, last_addr=1, start, t_ready=1.
- Response: t_valid at cycle 3 with t_out=16'h0400, sample_idx=0; t_valid at cycle 7 with t_out=0, sample_idx=1; done at cycle 8; epoch_cnt=1.
REQ-037 Stimulus: epochs=0, start.
- Response: done high for exactly one cycle, mem_en never high, busy stays 0.
REQ-038 Stimulus: epochs=3, last_addr=15, t_ready toggled randomly.
- Response: exactly 48 handshakes with sample_idx sequence 0..15 three times; t_out stable whenever t_valid=1 and t_ready=0; done once.
REQ-039 Stimulus: abort asserted in HOLD with t_ready=1 in the same cycle.
- Response: no NEXT, IDLE at the next edge, done never asserted, t_valid=0.
REQ-040 Stimulus: rst pulsed between clock edges during READ.
- Response: mem_en and busy drop without waiting for an edge.
- After release, all outputs are at reset values and a new start runs normally from address 0.
REQ-041 Stimulus: start pulsed again while busy, with new epochs/last_addr values.
- Response: the run continues unaffected and the handshake count matches the original parameters.
